iter_shifter: RTL and testbench

- Parametrised, multi-cycle variable shifter; successor to the combinational variable right shift.
- Supports logical right, arithmetic right, logical left and rotate right.
- Moves at most STEP bit positions per clock, so large widths close timing without a full barrel shifter.
- Sits between producer and consumer logic behind valid/ready handshakes on both sides.

---
 rtl/iter_shifter.sv | 113 +++++++++++
 tb/tb_iter_shifter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Multi-cycle variable shifter (LSR/ASR/LSL/ROR) with valid/ready handshakes on both sides.
// Shifts the working register by at most STEP positions per clock until the remaining amount is exhausted.
module iter_shifter #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 8,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam int RW = $clog2(WIDTH + 1);
   localparam logic [RW-1:0] WIDTH_R = RW'(WIDTH);
   localparam logic [RW-1:0] STEP_R  = RW'(STEP);
   localparam logic [31:0]   WIDTH_U = 32'(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work, work_nxt;
   logic [RW-1:0]    rem, rem_nxt, eff_amt, step_k;
   logic [1:0]       mode;
   logic             accept;
   logic [31:0]      amt_wide;

   assign accept   = in_valid && in_ready;
   assign amt_wide = 32'(in_amt);

   // Rotates wrap the amount; the other modes saturate at WIDTH, which already yields the all-zero / all-sign result.
   always_comb begin
      eff_amt = '0;
      if (in_mode == 2'd3)
         eff_amt = RW'(amt_wide % WIDTH_U);
      else if (amt_wide >= WIDTH_U)
         eff_amt = WIDTH_R;
      else
         eff_amt = RW'(amt_wide);
   end

   always_comb begin
      step_k   = (rem < STEP_R) ? rem : STEP_R;
      rem_nxt  = rem - step_k;
      work_nxt = work;
      case (mode)
         2'd0:    work_nxt = work >> step_k;
         2'd1:    work_nxt = $unsigned($signed(work) >>> step_k);
         2'd2:    work_nxt = work << step_k;
         default: work_nxt = (work >> step_k) | (work << (WIDTH_R - step_k));
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (eff_amt == '0) ? DONE : SHIFT;
         SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) && !reset;
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // out_data is only written on the way into DONE so it stays stable under backpressure and in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         work     <= '0;
         rem      <= '0;
         mode     <= '0;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  work <= in_data;
                  rem  <= eff_amt;
                  mode <= in_mode;
                  if (eff_amt == '0)
                     out_data <= in_data;
               end
            end
            SHIFT: begin
               work <= work_nxt;
               rem  <= rem_nxt;
               if (rem_nxt == '0)
                  out_data <= work_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: directed vector table on STEP=1 and STEP=2 instances,
// plus backpressure, mid-shift reset and back-to-back random sequences.
module tb_iter_shifter;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid1, in_valid2, out_ready;
   logic [7:0] in_data, in_amt;
   logic [1:0] in_mode;
   logic       in_ready1, out_valid1, busy1;
   logic       in_ready2, out_valid2, busy2;
   logic [7:0] out_data1, out_data2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   iter_shifter #(.WIDTH(8), .AMT_W(8), .STEP(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1));

   iter_shifter #(.WIDTH(8), .AMT_W(8), .STEP(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .busy(busy2));

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [7:0] amt;
      logic [1:0] mode;
      logic [7:0] exp;
      int         lat;
   } vec_t;

   vec_t vecs[19];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] refShift(input logic [7:0] d, input logic [7:0] a, input logic [1:0] m);
      int r;
      case (m)
         2'd0:    return (a >= 8) ? 8'h00 : d >> a;
         2'd1:    return (a >= 8) ? {8{d[7]}} : $unsigned($signed(d) >>> a);
         2'd2:    return (a >= 8) ? 8'h00 : d << a;
         default: begin
            r = int'(a) % 8;
            return (r == 0) ? d : ((d >> r) | (d << (8 - r)));
         end
      endcase
   endfunction

   // Issue one request to the selected instance and measure cycles until out_valid (out_ready assumed 1).
   task automatic applyStimulus(input int sel, input logic [7:0] d, input logic [7:0] a,
                                input logic [1:0] m, input logic [7:0] exp, input int lat, input string name);
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (!(sel == 1 ? in_ready2 : in_ready1) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      in_data = d;
      in_amt  = a;
      in_mode = m;
      if (sel == 1) in_valid2 = 1'b1; else in_valid1 = 1'b1;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      in_valid2 = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(sel == 1 ? out_valid2 : out_valid1) && cyc < 100);
      checkOutput({name, " latency"}, cyc, lat);
      checkOutput({name, " data"}, (sel == 1) ? out_data2 : out_data1, exp);
   endtask

   initial begin
      int accepted, results, cyc;
      logic [7:0] q[$];
      logic [7:0] e;

      vecs[0]  = '{0, 8'h80, 8'd0,   2'd0, 8'h80, 1};
      vecs[1]  = '{0, 8'h80, 8'd1,   2'd0, 8'h40, 2};
      vecs[2]  = '{0, 8'h80, 8'd2,   2'd0, 8'h20, 3};
      vecs[3]  = '{0, 8'h80, 8'd3,   2'd0, 8'h10, 4};
      vecs[4]  = '{0, 8'h80, 8'd4,   2'd0, 8'h08, 5};
      vecs[5]  = '{0, 8'h80, 8'd5,   2'd0, 8'h04, 6};
      vecs[6]  = '{0, 8'h80, 8'd6,   2'd0, 8'h02, 7};
      vecs[7]  = '{0, 8'h80, 8'd7,   2'd0, 8'h01, 8};
      vecs[8]  = '{0, 8'hA5, 8'd1,   2'd0, 8'h52, 2};
      vecs[9]  = '{0, 8'h80, 8'd3,   2'd1, 8'hF0, 4};
      vecs[10] = '{0, 8'h80, 8'd200, 2'd1, 8'hFF, 9};
      vecs[11] = '{0, 8'h01, 8'd9,   2'd2, 8'h00, 9};
      vecs[12] = '{0, 8'hA5, 8'd1,   2'd3, 8'hD2, 2};
      vecs[13] = '{0, 8'hA5, 8'd9,   2'd3, 8'hD2, 2};
      vecs[14] = '{1, 8'h80, 8'd7,   2'd0, 8'h01, 5};
      vecs[15] = '{1, 8'h80, 8'd0,   2'd0, 8'h80, 1};
      vecs[16] = '{1, 8'h80, 8'd5,   2'd1, 8'hFC, 4};
      vecs[17] = '{1, 8'hA5, 8'd3,   2'd3, 8'hB4, 3};
      vecs[18] = '{1, 8'h81, 8'd8,   2'd2, 8'h00, 5};

      reset     = 1'b1;
      in_valid1 = 1'b0;
      in_valid2 = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      in_amt    = '0;
      in_mode   = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset in_ready", in_ready1, 0);
      checkOutput("reset out_valid", out_valid1, 0);
      checkOutput("reset busy", busy1, 0);
      checkOutput("reset out_data", out_data1, 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post-reset in_ready", in_ready1, 1);
      checkOutput("post-reset in_ready step2", in_ready2, 1);

      for (int i = 0; i < 19; i++)
         applyStimulus(vecs[i].sel, vecs[i].data, vecs[i].amt, vecs[i].mode,
                       vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

      // Backpressure: hold DONE for 10 cycles with a competing request pending.
      out_ready = 1'b0;
      applyStimulus(0, 8'h80, 8'd2, 2'd0, 8'h20, 3, "bp");
      in_data   = 8'hFF;
      in_amt    = 8'd0;
      in_mode   = 2'd0;
      in_valid1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp out_valid", out_valid1, 1);
         checkOutput("bp out_data", out_data1, 8'h20);
         checkOutput("bp in_ready", in_ready1, 0);
      end
      in_valid1 = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp release in_ready", in_ready1, 1);
      checkOutput("bp release out_valid", out_valid1, 0);
      checkOutput("bp pending not taken", busy1, 0);

      // Reset during the third shift cycle discards the operation.
      in_data   = 8'h80;
      in_amt    = 8'd7;
      in_mode   = 2'd0;
      in_valid1 = 1'b1;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("mid busy before reset", busy1, 1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid reset busy", busy1, 0);
      checkOutput("mid reset out_valid", out_valid1, 0);
      checkOutput("mid reset out_data", out_data1, 0);
      checkOutput("mid reset in_ready", in_ready1, 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("mid after in_ready", in_ready1, 1);
      cyc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid1) cyc++;
      end
      checkOutput("mid no result emitted", cyc, 0);
      applyStimulus(0, 8'h80, 8'd7, 2'd0, 8'h01, 8, "mid recover");

      // Back-to-back random requests with in_valid and out_ready held high.
      accepted = 0;
      results  = 0;
      cyc      = 0;
      in_data  = 8'($urandom);
      in_amt   = 8'($urandom_range(0, 12));
      in_mode  = 2'($urandom_range(0, 3));
      in_valid1 = 1'b1;
      while (results < 10 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (out_valid1) begin
            if (q.size() == 0) begin
               checkOutput("b2b unexpected result", 1, 0);
            end else begin
               e = q.pop_front();
               checkOutput($sformatf("b2b result %0d", results), out_data1, e);
            end
            results++;
         end
         if (in_valid1 && in_ready1) begin
            q.push_back(refShift(in_data, in_amt, in_mode));
            accepted++;
            @(posedge clk);
            #1;
            in_data = 8'($urandom);
            in_amt  = 8'($urandom_range(0, 12));
            in_mode = 2'($urandom_range(0, 3));
            if (accepted == 10) in_valid1 = 1'b0;
         end
      end
      in_valid1 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("b2b accepted count", accepted, 10);
      checkOutput("b2b result count", results, 10);
      checkOutput("b2b idle at end", busy1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
